// File: rtl/ifetch.sv
// Fetch stage between the PC and decode: req/ack to instruction memory, DEPTH-entry output FIFO.
// Optional IFETCH_ALIGN_CHK_EN turns a misaligned PC into a sticky fault instead of a fetch.
module ifetch #(
    parameter int DEPTH = 2
) (
    input  logic        ifetch_clk,
    input  logic        ifetch_rst,
    input  logic [31:0] ifetch_pc,
    output logic        ifetch_pc_adv,
    input  logic        ifetch_flush,
    output logic        ifetch_mem_req,
    output logic [31:0] ifetch_mem_addr,
    input  logic        ifetch_mem_ack,
    input  logic [31:0] ifetch_mem_rdata,
    output logic [31:0] ifetch_inst,
    output logic [31:0] ifetch_inst_pc,
    output logic        ifetch_valid,
    input  logic        ifetch_ready,
    output logic        ifetch_fault
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        ADV,
        DRAIN
    } state_t;

    state_t           state;
    logic [31:0]      inst_mem [DEPTH];
    logic [31:0]      pc_mem   [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             issue_ok;
    logic             push;
    logic             pop;

    assign push          = (state == REQ) && ifetch_mem_ack && !ifetch_flush;
    assign pop           = ifetch_valid && ifetch_ready && !ifetch_flush;
    assign ifetch_valid  = (count != '0);
    assign ifetch_inst   = inst_mem[rd_ptr];
    assign ifetch_inst_pc = pc_mem[rd_ptr];
    assign ifetch_pc_adv = (state == ADV) && !ifetch_flush;

`ifdef IFETCH_ALIGN_CHK_EN
    logic fault;
    logic misaligned;

    assign misaligned   = (ifetch_pc[1:0] != 2'b00);
    assign issue_ok     = !fault && !misaligned;
    assign ifetch_fault = fault;

    // Sticky until a redirect supplies a new PC; blocks issue while set.
    always_ff @(posedge ifetch_clk or posedge ifetch_rst) begin
        if (ifetch_rst) begin
            fault <= 1'b0;
        end else if (ifetch_flush) begin
            fault <= 1'b0;
        end else if (state == IDLE && misaligned) begin
            fault <= 1'b1;
        end
    end
`else
    assign issue_ok     = 1'b1;
    assign ifetch_fault = 1'b0;
`endif

    always_ff @(posedge ifetch_clk or posedge ifetch_rst) begin
        if (ifetch_rst) begin
            state           <= IDLE;
            ifetch_mem_req  <= 1'b0;
            ifetch_mem_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!ifetch_flush && issue_ok && count < FULL) begin
                        state           <= REQ;
                        ifetch_mem_req  <= 1'b1;
                        ifetch_mem_addr <= ifetch_pc & 32'hFFFF_FFFC;
                    end
                end
                REQ: begin
                    // A flushed request must still see its ack before the bus is free again.
                    if (ifetch_mem_ack) begin
                        ifetch_mem_req <= 1'b0;
                        state          <= ifetch_flush ? IDLE : ADV;
                    end else if (ifetch_flush) begin
                        state <= DRAIN;
                    end
                end
                ADV: begin
                    state <= IDLE;
                end
                DRAIN: begin
                    if (ifetch_mem_ack) begin
                        ifetch_mem_req <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Flush outranks push and pop; issue is gated on count so the FIFO never overflows.
    always_ff @(posedge ifetch_clk or posedge ifetch_rst) begin
        if (ifetch_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                inst_mem[i] <= '0;
                pc_mem[i]   <= '0;
            end
        end else if (ifetch_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                inst_mem[wr_ptr] <= ifetch_mem_rdata;
                pc_mem[wr_ptr]   <= ifetch_mem_addr;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch.sv
// Scoreboard bench for ifetch: stimulus queues expected (inst, pc) pairs, a monitor pops them on each FIFO pop.
// A simple PC stage steps pc by 4 on pc_adv; the memory model answers with rdata = 0xA0 + addr.
module tb_ifetch;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pc = '0;
    logic        pc_adv;
    logic        flush = 1'b1;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        valid;
    logic        ready = 1'b0;
    logic        fault;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } exp_t;

    exp_t exp_q[$];
    int   check_count = 0;
    int   pass_count  = 0;
    int   adv_total   = 0;
    int   adv_mark    = 0;
    int   mem_wait    = 0;
    int   wait_cnt    = 0;
    bit   done        = 1'b0;

    ifetch #(.DEPTH(2)) dut (
        .ifetch_clk       (clk),
        .ifetch_rst       (rst),
        .ifetch_pc        (pc),
        .ifetch_pc_adv    (pc_adv),
        .ifetch_flush     (flush),
        .ifetch_mem_req   (mem_req),
        .ifetch_mem_addr  (mem_addr),
        .ifetch_mem_ack   (mem_ack),
        .ifetch_mem_rdata (mem_rdata),
        .ifetch_inst      (inst),
        .ifetch_inst_pc   (inst_pc),
        .ifetch_valid     (valid),
        .ifetch_ready     (ready),
        .ifetch_fault     (fault)
    );

    always #5 clk = ~clk;

    // Memory acks after mem_wait idle cycles of a held request; a dropped request resets the wait.
    always @(posedge clk) begin
        #1;
        if (mem_req && wait_cnt == mem_wait) begin
            mem_ack   = 1'b1;
            mem_rdata = 32'hA0 + mem_addr;
        end else if (mem_req) begin
            mem_ack  = 1'b0;
            wait_cnt = wait_cnt + 1;
        end else begin
            mem_ack  = 1'b0;
            wait_cnt = 0;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic f, input logic [31:0] p, input logic r);
        flush = f;
        pc    = p;
        ready = r;
    endtask

    task automatic expectFetch(input logic [31:0] i, input logic [31:0] p);
        exp_t e;
        e.inst = i;
        e.pc   = p;
        exp_q.push_back(e);
    endtask

    // One clock: pc_adv is sampled before the edge, the PC stage steps just after it.
    task automatic cycle();
        logic adv_pre;
        @(negedge clk);
        adv_pre = pc_adv;
        @(posedge clk);
        #1;
        if (adv_pre) begin
            pc = pc + 32'd4;
            adv_total++;
        end
    endtask

    task automatic park();
        flush = 1'b1;
        cycle();
        cycle();
        exp_q.delete();
    endtask

    initial begin
        fork
            begin
                while (!done) begin
                    @(negedge clk);
                    if (!rst && valid && ready && !flush) begin
                        if (exp_q.size() == 0) begin
                            check_count++;
                            $display("[TB] FAIL unexpected_pop: got inst_pc 0x%08h, expected no entry", inst_pc);
                        end else begin
                            exp_t e;
                            e = exp_q.pop_front();
                            checkOutput("inst", inst, e.inst);
                            checkOutput("inst_pc", inst_pc, e.pc);
                        end
                    end
                end
            end
            begin
                // Reset state
                #1 rst = 1'b1;
                cycle();
                cycle();
                checkOutput("rst_req", 32'(mem_req), 32'd0);
                checkOutput("rst_addr", mem_addr, 32'd0);
                checkOutput("rst_adv", 32'(pc_adv), 32'd0);
                checkOutput("rst_valid", 32'(valid), 32'd0);
                checkOutput("rst_inst", inst, 32'd0);
                checkOutput("rst_inst_pc", inst_pc, 32'd0);
                checkOutput("rst_fault", 32'(fault), 32'd0);
                rst = 1'b0;
                cycle();

                // T1: zero-wait stream 0,4,8
                $display("[TB] zero-wait stream");
                adv_mark = adv_total;
                applyStimulus(1'b0, 32'h0, 1'b1);
                expectFetch(32'hA0, 32'h0);
                expectFetch(32'hA4, 32'h4);
                expectFetch(32'hA8, 32'h8);
                for (int k = 0; k < 3; k++) begin
                    cycle();
                    checkOutput("t1_req", 32'(mem_req), 32'd1);
                    checkOutput("t1_addr", mem_addr, 32'(k * 4));
                    cycle();
                    checkOutput("t1_adv", 32'(pc_adv), 32'd1);
                    cycle();
                    checkOutput("t1_req_low", 32'(mem_req), 32'd0);
                end
                checkOutput("t1_adv_count", 32'(adv_total - adv_mark), 32'd3);
                checkOutput("t1_drained", 32'(exp_q.size()), 32'd0);
                park();

                // T2: backpressure fills DEPTH=2, one pop frees a slot
                $display("[TB] backpressure");
                adv_mark = adv_total;
                applyStimulus(1'b1, 32'h0, 1'b0);
                expectFetch(32'hA0, 32'h0);
                expectFetch(32'hA4, 32'h4);
                expectFetch(32'hA8, 32'h8);
                flush = 1'b0;
                repeat (6) cycle();
                for (int k = 0; k < 3; k++) begin
                    cycle();
                    checkOutput("t2_full_req", 32'(mem_req), 32'd0);
                end
                checkOutput("t2_valid", 32'(valid), 32'd1);
                checkOutput("t2_head_pc", inst_pc, 32'h0);
                ready = 1'b1;
                cycle();
                ready = 1'b0;
                checkOutput("t2_head_pc_next", inst_pc, 32'h4);
                cycle();
                checkOutput("t2_reissue_req", 32'(mem_req), 32'd1);
                checkOutput("t2_reissue_addr", mem_addr, 32'h8);
                cycle();
                checkOutput("t2_adv", 32'(pc_adv), 32'd1);
                flush = 1'b1;
                #1;
                checkOutput("t2_adv_flushed", 32'(pc_adv), 32'd0);
                cycle();
                checkOutput("t2_flush_valid", 32'(valid), 32'd0);
                checkOutput("t2_adv_count", 32'(adv_total - adv_mark), 32'd2);
                park();

                // T3: flush while waiting on a slow ack, redirect to 0x100
                $display("[TB] flush during slow request");
                adv_mark = adv_total;
                mem_wait = 3;
                applyStimulus(1'b0, 32'h40, 1'b1);
                cycle();
                checkOutput("t3_req", 32'(mem_req), 32'd1);
                checkOutput("t3_addr", mem_addr, 32'h40);
                applyStimulus(1'b1, 32'h100, 1'b1);
                cycle();
                flush = 1'b0;
                checkOutput("t3_drain_req0", 32'(mem_req), 32'd1);
                checkOutput("t3_drain_addr", mem_addr, 32'h40);
                cycle();
                checkOutput("t3_drain_req1", 32'(mem_req), 32'd1);
                cycle();
                checkOutput("t3_drain_req2", 32'(mem_req), 32'd1);
                cycle();
                checkOutput("t3_drain_done", 32'(mem_req), 32'd0);
                checkOutput("t3_valid", 32'(valid), 32'd0);
                checkOutput("t3_no_adv", 32'(adv_total - adv_mark), 32'd0);
                expectFetch(32'h1A0, 32'h100);
                cycle();
                checkOutput("t3_new_req", 32'(mem_req), 32'd1);
                checkOutput("t3_new_addr", mem_addr, 32'h100);
                repeat (5) cycle();
                checkOutput("t3_adv_count", 32'(adv_total - adv_mark), 32'd1);
                checkOutput("t3_drained", 32'(exp_q.size()), 32'd0);
                park();

                // T4: flush coincides with ack while one entry is buffered
                $display("[TB] flush with ack");
                adv_mark = adv_total;
                mem_wait = 0;
                applyStimulus(1'b0, 32'h200, 1'b0);
                repeat (4) cycle();
                checkOutput("t4_req", 32'(mem_req), 32'd1);
                checkOutput("t4_addr", mem_addr, 32'h204);
                checkOutput("t4_buffered", 32'(valid), 32'd1);
                flush = 1'b1;
                cycle();
                exp_q.delete();
                flush = 1'b0;
                #1;
                checkOutput("t4_valid", 32'(valid), 32'd0);
                checkOutput("t4_adv", 32'(pc_adv), 32'd0);
                checkOutput("t4_req_low", 32'(mem_req), 32'd0);
                cycle();
                checkOutput("t4_reissue_req", 32'(mem_req), 32'd1);
                checkOutput("t4_reissue_addr", mem_addr, 32'h204);
                checkOutput("t4_adv_count", 32'(adv_total - adv_mark), 32'd1);
                park();

                // T5: async reset with a request outstanding and one entry buffered
                $display("[TB] reset mid-request");
                adv_mark = adv_total;
                applyStimulus(1'b0, 32'h300, 1'b0);
                cycle();
                cycle();
                mem_wait = 5;
                cycle();
                cycle();
                checkOutput("t5_req", 32'(mem_req), 32'd1);
                checkOutput("t5_buffered", 32'(valid), 32'd1);
                #2;
                rst = 1'b1;
                #1;
                checkOutput("t5_rst_req", 32'(mem_req), 32'd0);
                checkOutput("t5_rst_addr", mem_addr, 32'd0);
                checkOutput("t5_rst_adv", 32'(pc_adv), 32'd0);
                checkOutput("t5_rst_valid", 32'(valid), 32'd0);
                checkOutput("t5_rst_inst", inst, 32'd0);
                checkOutput("t5_rst_inst_pc", inst_pc, 32'd0);
                checkOutput("t5_rst_fault", 32'(fault), 32'd0);
                exp_q.delete();
                mem_wait = 0;
                applyStimulus(1'b0, 32'h400, 1'b1);
                expectFetch(32'h4A0, 32'h400);
                cycle();
                rst = 1'b0;
                cycle();
                checkOutput("t5_first_req", 32'(mem_req), 32'd1);
                checkOutput("t5_first_addr", mem_addr, 32'h400);
                cycle();
                cycle();
                checkOutput("t5_adv_count", 32'(adv_total - adv_mark), 32'd2);
                checkOutput("t5_drained", 32'(exp_q.size()), 32'd0);
                park();

                // T6: misaligned PC
                $display("[TB] misaligned pc");
                adv_mark = adv_total;
`ifdef IFETCH_ALIGN_CHK_EN
                applyStimulus(1'b0, 32'h102, 1'b1);
                cycle();
                checkOutput("t6_fault", 32'(fault), 32'd1);
                checkOutput("t6_no_req", 32'(mem_req), 32'd0);
                cycle();
                checkOutput("t6_fault_sticky", 32'(fault), 32'd1);
                checkOutput("t6_no_req_sticky", 32'(mem_req), 32'd0);
                applyStimulus(1'b1, 32'h104, 1'b1);
                cycle();
                checkOutput("t6_fault_clear", 32'(fault), 32'd0);
                expectFetch(32'h1A4, 32'h104);
                flush = 1'b0;
                cycle();
                checkOutput("t6_req", 32'(mem_req), 32'd1);
                checkOutput("t6_addr", mem_addr, 32'h104);
`else
                expectFetch(32'h1A0, 32'h100);
                applyStimulus(1'b0, 32'h102, 1'b1);
                cycle();
                checkOutput("t6_req", 32'(mem_req), 32'd1);
                checkOutput("t6_addr", mem_addr, 32'h100);
                checkOutput("t6_fault", 32'(fault), 32'd0);
`endif
                cycle();
                cycle();
                checkOutput("t6_fault_end", 32'(fault), 32'd0);
                checkOutput("t6_adv_count", 32'(adv_total - adv_mark), 32'd1);
                checkOutput("t6_drained", 32'(exp_q.size()), 32'd0);
                park();

                done = 1'b1;
            end
        join
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
